// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler FSM states and baud divisor.
// Reused by the transmitter, receiver and tx scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  function automatic int baud_div(input int baud, input int freq);
    return freq / baud;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running baud tick: counts 0..DIV-1, one-cycle tick at DIV-1.
// Runs regardless of scheduler state or enable.
module baud_gen
  import uart_pkg::*;
#(
  parameter int baudRate = 9600,
  parameter int freq_Sys = 125000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = baud_div(baudRate, freq_Sys);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler in front of a UART transmitter.
// One byte in flight; grant pointer resumes after the last winner.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int baudRate = 9600,
  parameter int freq_Sys = 125000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_en,
  output logic                       tx_send,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic          grant;
  logic          found;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;
  int            idx;

  baud_gen #(
    .baudRate (baudRate),
    .freq_Sys (freq_Sys)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tx_en)
  );

  // First pending requester after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = grant_id;
    cand  = grant_id;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(grant_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && found && !tx_busy) begin
          grant     = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= '0;
      tx_byte   <= '0;
      grant_id  <= LAST_ID;
    end else begin
      req_ready <= '0;
      if (grant) begin
        req_ready[win] <= 1'b1;
        tx_byte        <= req_data[{win, 3'b000} +: 8];
        grant_id       <= win;
      end
    end
  end

  assign tx_send = (state == LAUNCH) || (state == WAIT_BUSY);
  assign active  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: random requesters, transmitter model, reference model.
// A second default-parameter instance checks the 9600/125MHz tick period.
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int BAUD = 100;
  localparam int FREQ = 1600;
  localparam int DIV  = FREQ / BAUD;
  localparam int DIV2 = 125000000 / 9600;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_en;
  logic           tx_send;
  logic [7:0]     tx_byte;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;

  logic           rst2_n = 1'b0;
  logic [N-1:0]   rdy2;
  logic           tx_en2;
  logic           send2;
  logic [7:0]     byte2;
  logic [1:0]     gid2;
  logic           act2;

  logic       ext_busy = 1'b0;
  logic       x_busy;
  logic       frame_done;
  logic [9:0] frame_cap;
  int         bitn;
  bit         refill = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ  (N),
    .baudRate (BAUD),
    .freq_Sys (FREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_send   (tx_send),
    .tx_byte   (tx_byte),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  uart_tx_scheduler dut2 (
    .clk       (clk),
    .rst_n     (rst2_n),
    .enable    (1'b0),
    .req_valid (4'b0000),
    .req_data  (32'h0),
    .req_ready (rdy2),
    .tx_en     (tx_en2),
    .tx_send   (send2),
    .tx_byte   (byte2),
    .tx_busy   (1'b0),
    .grant_id  (gid2),
    .active    (act2)
  );

  assign tx_busy = x_busy | ext_busy;

  // Transmitter model: reads tx_byte live at every baud tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_busy     <= 1'b0;
      bitn       <= 0;
      frame_done <= 1'b0;
      frame_cap  <= '1;
    end else begin
      frame_done <= 1'b0;
      if (!x_busy) begin
        if (tx_send && !ext_busy) begin
          x_busy <= 1'b1;
          bitn   <= 0;
        end
      end else if (tx_en) begin
        if (bitn == 0) frame_cap[0] <= 1'b0;
        else if (bitn == 9) frame_cap[9] <= 1'b1;
        else if (bitn < 9) frame_cap[bitn] <= tx_byte[bitn-1];
        if (bitn == 10) begin
          x_busy     <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          bitn <= bitn + 1;
        end
      end
    end
  end

  int k_edge = 0;
  int k2 = 0;
  int pulses2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k_edge <= 0;
    else        k_edge <= k_edge + 1;
  end

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) k2 <= 0;
    else         k2 <= k2 + 1;
  end

  // Requesters hold valid until accepted; refill keeps them pending.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (refill) req_data[8*i +: 8] = 8'($urandom);
        else        req_valid[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int from);
    for (int s = 1; s <= N; s++) begin
      if (v[(from + s) % N]) return (from + s) % N;
    end
    return -1;
  endfunction

  // Reference model: phase 0 idle, 1 launch, 2 await busy, 3 await done.
  int             ph = 0;
  int             ptr = N - 1;
  logic [7:0]     exp_byte = '0;
  logic [7:0]     sb[$];
  int             gnt_log[$];
  logic           p_en = 1'b0;
  logic [N-1:0]   p_valid = '0;
  logic [8*N-1:0] p_data = '0;
  logic           p_busy = 1'b0;
  int             last_k = 0;
  logic [N-1:0]   exp_rdy;
  int             w;
  logic [7:0]     e;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph       = 0;
      ptr      = N - 1;
      exp_byte = '0;
      sb.delete();
      chk("rst_outputs", {req_ready, tx_send, active, tx_en}, 0);
      chk("rst_byte", tx_byte, 0);
      chk("rst_grant_id", grant_id, N - 1);
    end else if (k_edge != last_k) begin
      exp_rdy = '0;
      case (ph)
        0: begin
          if (p_en && p_valid != 0 && !p_busy) begin
            w          = rr_pick(p_valid, ptr);
            exp_rdy[w] = 1'b1;
            ptr        = w;
            exp_byte   = p_data[8*w +: 8];
            sb.push_back(exp_byte);
            gnt_log.push_back(w);
            ph = 1;
          end
        end
        1: ph = 2;
        2: if (p_busy) ph = 3;
        default: if (!p_busy) ph = 0;
      endcase
      chk("req_ready", req_ready, exp_rdy);
      chk("grant_id", grant_id, ptr);
      chk("tx_send", tx_send, (ph == 1) || (ph == 2));
      chk("active", active, ph != 0);
      if (ph != 0) chk("tx_byte", tx_byte, exp_byte);
      if (tx_en || (k_edge % DIV == DIV - 1))
        chk("tx_en", tx_en, k_edge % DIV == DIV - 1);
      if (frame_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: unexpected frame %0h", frame_cap);
        end else begin
          e = sb.pop_front();
          chk("frame", frame_cap, {1'b1, e, 1'b0});
        end
      end
    end
    if (rst2_n && (tx_en2 || (k2 % DIV2 == DIV2 - 1))) begin
      chk("tx_en_9600", tx_en2, k2 % DIV2 == DIV2 - 1);
      if (tx_en2) pulses2++;
    end
    last_k  = k_edge;
    p_en    = enable;
    p_valid = req_valid;
    p_data  = req_data;
    p_busy  = tx_busy;
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_grant(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (req_ready != 0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_grant: no grant in %0d cycles", budget);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (!active && !tx_busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: still busy after %0d cycles", budget);
  endtask

  task automatic wait_wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (active && tx_busy && !tx_send) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: not reached in %0d cycles", budget);
  endtask

  int n0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    enable = 1'b1;
    repeat (2 * DIV + 3) step();

    // single requester, one-cycle grant latency
    step();
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    @(negedge clk);
    chk("lat_before", req_ready, 0);
    @(negedge clk);
    chk("lat_grant", req_ready, 4'b0001);
    wait_idle(400);

    // enable dropped in WAIT_BUSY
    step();
    req_data[15:8] = 8'($urandom);
    req_valid[1]   = 1'b1;
    wait_grant(10);
    step();
    enable          = 1'b0;
    req_data[31:24] = 8'($urandom);
    req_valid[3]    = 1'b1;
    wait_idle(400);
    n0 = gnt_log.size();
    repeat (40) step();
    chk("enable_hold", gnt_log.size(), n0);
    enable = 1'b1;
    wait_grant(10);
    chk("enable_resume", gnt_log[$], 3);
    wait_idle(400);

    // external busy blocks grants in IDLE
    step();
    ext_busy        = 1'b1;
    req_data[23:16] = 8'($urandom);
    req_valid       = 4'b0100;
    n0 = gnt_log.size();
    repeat (30) step();
    chk("busy_block", gnt_log.size(), n0);
    ext_busy = 1'b0;
    wait_grant(10);
    chk("busy_release", gnt_log[$], 2);
    wait_idle(400);

    // reset in WAIT_DONE, then round-robin from requester 0
    step();
    req_data[7:0] = 8'($urandom);
    req_valid     = 4'b0001;
    wait_grant(10);
    wait_wait_done(100);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_send", tx_send, 0);
    chk("rst_mid_active", active, 0);
    chk("rst_mid_grant_id", grant_id, N - 1);
    refill = 1'b1;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
    req_valid = 4'b1111;
    repeat (2) step();
    gnt_log.delete();
    rst_n = 1'b1;
    for (int n = 0; n < 3000 && gnt_log.size() < 5; n++) begin
      @(negedge clk);
      #1;
    end
    step();
    refill    = 1'b0;
    req_valid = '0;
    chk("rr_count", gnt_log.size(), 5);
    for (int j = 0; j < 5; j++) begin
      if (j < gnt_log.size()) chk("rr_order", gnt_log[j], rr_exp[j]);
    end
    wait_idle(400);

    // random traffic with drops and enable toggles
    repeat (3000) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(7) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req_valid[i]       = 1'b1;
        end else if (req_valid[i] && $urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(99) == 0) enable = ~enable;
    end
    enable    = 1'b1;
    req_valid = '0;
    wait_idle(600);
    repeat (5) step();

    // let the default-rate instance show two full tick periods
    for (int n = 0; n < 30000 && k2 < 2 * DIV2 + 5; n++) step();
    chk("tick_count_9600", pulses2, k2 / DIV2);
    chk("tick_seen_9600", pulses2 >= 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
